// File: rtl/uart_tx_queue.sv
// Circular byte FIFO and launch controller that sits ahead of the UART transmitter FSM.
// A byte is presented with DataValid until Busy rises; the next byte waits for Busy to fall.
module uart_tx_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  TXQ_CLK,
  input  logic                  TXQ_RST_ASYN,
  input  logic                  TXQ_WrEn,
  input  logic [DATA_WIDTH-1:0] TXQ_WrData,
  output logic                  TXQ_Full,
  output logic                  TXQ_Empty,
  output logic [ADDR_WIDTH:0]   TXQ_Count,
  output logic                  TXQ_Overflow,
  input  logic                  TXQ_OvfClr,
  input  logic                  TXQ_TxBusy,
  output logic                  TXQ_DataValid,
  output logic [DATA_WIDTH-1:0] TXQ_TxData
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic full, empty;
  logic wr_accept, wr_reject, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Full is judged on the pre-edge occupancy, so a same-cycle pop never rescues a write.
  assign wr_accept = TXQ_WrEn & ~full;
  assign wr_reject = TXQ_WrEn &  full;
  assign pop       = (state_q == IDLE) & ~empty & ~TXQ_TxBusy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_reject) begin
      ovf_d = 1'b1;
    end else if (TXQ_OvfClr) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        if (TXQ_TxBusy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!TXQ_TxBusy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge TXQ_CLK or posedge TXQ_RST_ASYN) begin
    if (TXQ_RST_ASYN) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge TXQ_CLK) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= TXQ_WrData;
    end
  end

  assign TXQ_Full      = full;
  assign TXQ_Empty     = empty;
  assign TXQ_Count     = count_q;
  assign TXQ_Overflow  = ovf_q;
  assign TXQ_DataValid = (state_q == LAUNCH);
  assign TXQ_TxData    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized bench for uart_tx_queue against a queue-based reference model.
module tb_uart_tx_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          ovf_clr;
  logic          busy_req;
  logic          busy_auto;
  int            mode;
  int            frame_len;
  logic          tx_busy;

  logic          full, empty, ovf, dv;
  logic [AW:0]   count;
  logic [DW-1:0] tx_data;

  int n_checks = 0;
  int n_pass   = 0;

  assign tx_busy = (mode == 0) ? busy_req : busy_auto;

  uart_tx_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .TXQ_CLK      (clk),
    .TXQ_RST_ASYN (rst),
    .TXQ_WrEn     (wr_en),
    .TXQ_WrData   (wr_data),
    .TXQ_Full     (full),
    .TXQ_Empty    (empty),
    .TXQ_Count    (count),
    .TXQ_Overflow (ovf),
    .TXQ_OvfClr   (ovf_clr),
    .TXQ_TxBusy   (tx_busy),
    .TXQ_DataValid(dv),
    .TXQ_TxData   (tx_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a byte queue plus the launch phase of the frame on offer.
  // phase 0 = nothing offered, 1 = byte offered, 2 = transmitter still sending it.
  logic [DW-1:0] mq[$];
  int            m_phase = 0;
  logic [DW-1:0] m_tx    = '0;
  bit            m_ovf   = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_phase = 0;
        m_tx    = '0;
        m_ovf   = 1'b0;
      end else begin
        bit was_full;
        was_full = (mq.size() == DEPTH);
        if (m_phase == 0 && mq.size() > 0 && !tx_busy) begin
          m_tx    = mq.pop_front();
          m_phase = 1;
        end else if (m_phase == 1 && tx_busy) begin
          m_phase = 2;
        end else if (m_phase == 2 && !tx_busy) begin
          m_phase = 0;
        end
        if (wr_en && !was_full) mq.push_back(wr_data);
        if (wr_en && was_full) m_ovf = 1'b1;
        else if (ovf_clr)      m_ovf = 1'b0;
      end
    end
  end

  // Every-cycle comparison plus capture of each byte at its DataValid rise.
  logic [DW-1:0] launched[$];
  bit            dv_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      chk("count",  int'(count),   mq.size());
      chk("full",   int'(full),    int'(mq.size() == DEPTH));
      chk("empty",  int'(empty),   int'(mq.size() == 0));
      chk("ovf",    int'(ovf),     int'(m_ovf));
      chk("dv",     int'(dv),      int'(m_phase == 1));
      chk("txdata", int'(tx_data), int'(m_tx));
      if (dv && !dv_prev) launched.push_back(tx_data);
      dv_prev = dv;
    end
  end

  // Transmitter stand-in: mode 1 answers each DataValid with a Busy pulse,
  // mode 2 drives Busy at random regardless of the handshake.
  initial begin
    int busy_cnt;
    busy_cnt  = 0;
    busy_auto = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 2) begin
        busy_auto = ($urandom_range(0, 3) == 0);
        busy_cnt  = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) busy_auto = 1'b0;
      end else if (dv && !busy_auto) begin
        busy_auto = 1'b1;
        busy_cnt  = (frame_len > 0) ? frame_len : $urandom_range(1, 12);
      end else begin
        busy_auto = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(mq.size() == 0 && m_phase == 0 && !tx_busy) && n < 2000) begin
      step();
      n++;
    end
    chk(name, int'(n < 2000), 1);
  endtask

  initial begin
    logic [DW-1:0] vals[8];
    logic [DW-1:0] v2[4];

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
    busy_req = 1'b0; mode = 0; frame_len = 11;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full),  0);
    chk("rst_ovf",   int'(ovf),   0);
    chk("rst_dv",    int'(dv),    0);
    chk("rst_tx",    int'(tx_data), 0);

    // Single byte: DataValid one cycle after the write edge.
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    chk("t1_count_after_wr", int'(count), 1);
    step();
    chk("t1_dv",    int'(dv),      1);
    chk("t1_tx",    int'(tx_data), 8'hA5);
    chk("t1_count", int'(count),   0);
    busy_req = 1'b1;
    step();
    chk("t1_dv_drop", int'(dv), 0);
    busy_req = 1'b0;
    step();
    chk("t1_idle_dv", int'(dv), 0);
    chk("t1_empty",   int'(empty), 1);

    // Three frames with an 11-cycle Busy each.
    launched.delete();
    mode = 1; frame_len = 11;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = DW'((i + 1) * 8'h11);
      step();
    end
    wr_en = 1'b0;
    drain("t2_drain");
    chk("t2_nlaunch", launched.size(), 3);
    for (int i = 0; i < 3 && i < launched.size(); i++)
      chk("t2_order", int'(launched[i]), (i + 1) * 8'h11);
    chk("t2_empty", int'(empty), 1);

    // Fill while blocked, then overflow and clear.
    mode = 0; busy_req = 1'b1;
    step();
    launched.delete();
    for (int i = 0; i < 8; i++) begin
      vals[i] = DW'($urandom_range(0, 8'hFD));
      wr_en = 1'b1; wr_data = vals[i];
      step();
    end
    wr_en = 1'b0;
    chk("t3_full",  int'(full),  1);
    chk("t3_count", int'(count), 8);
    wr_en = 1'b1; wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("t3_ovf",       int'(ovf),   1);
    chk("t3_count_ovf", int'(count), 8);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", int'(ovf), 0);

    // Write on the pop cycle while full is still rejected.
    busy_req = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0; busy_req = 1'b1;
    chk("t4_ovf",   int'(ovf),     1);
    chk("t4_count", int'(count),   7);
    chk("t4_tx",    int'(tx_data), int'(vals[0]));
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    mode = 1; frame_len = 3;
    drain("t4_drain");
    chk("t4_nlaunch", launched.size(), 8);
    for (int i = 0; i < 8 && i < launched.size(); i++)
      chk("t4_order", int'(launched[i]), int'(vals[i]));

    // Transmitter never answers: byte stays offered, nothing else popped.
    mode = 0; busy_req = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      v2[i] = DW'($urandom);
      wr_en = 1'b1; wr_data = v2[i];
      step();
    end
    wr_en = 1'b0;
    repeat (30) step();
    chk("t5_dv",    int'(dv),      1);
    chk("t5_tx",    int'(tx_data), int'(v2[0]));
    chk("t5_count", int'(count),   3);

    // Asynchronous reset mid-LAUNCH.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_dv_async",    int'(dv),    0);
    chk("t6_count_async", int'(count), 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_count", int'(count), 0);
    chk("t6_empty", int'(empty), 1);

    // Random traffic against a randomly busy transmitter.
    mode = 2;
    for (int i = 0; i < 1500; i++) begin
      wr_en   = $urandom_range(0, 1) == 1;
      wr_data = DW'($urandom);
      ovf_clr = $urandom_range(0, 7) == 0;
      step();
    end
    // Random traffic against a handshaking transmitter with random frame length.
    mode = 1; frame_len = 0;
    for (int i = 0; i < 1500; i++) begin
      wr_en   = $urandom_range(0, 2) == 0;
      wr_data = DW'($urandom);
      ovf_clr = $urandom_range(0, 7) == 0;
      step();
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
